fetch_queue_mw: RTL and testbench

//  Multi-width instruction fetch queue between fetch and decode. Generalises the per-lane fetch buffer to a single compacting circular queue.

---
 rtl/fetch_queue_mw.sv | 113 +++++++++++
 tb/tb_fetch_queue_mw.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/fetch_queue_mw.sv
// Compacting multi-width fetch queue: sparse fetch groups are packed into a
// circular buffer and the oldest OUT_W entries are presented to decode.
module fetch_queue_mw #(
  parameter int ENTRY_W  = 64,
  parameter int IN_W     = 4,
  parameter int OUT_W    = 4,
  parameter int LOGDEPTH = 4,
  localparam int DEPTH   = 2**LOGDEPTH,
  localparam int CW      = $clog2(DEPTH+1),
  localparam int DCW     = $clog2(OUT_W+1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     enq_valid,
  input  logic [IN_W-1:0]          enq_mask,
  input  logic [IN_W*ENTRY_W-1:0]  enq_data,
  output logic                     enq_ready,
  output logic [OUT_W*ENTRY_W-1:0] deq_data,
  output logic [OUT_W-1:0]         deq_valid,
  input  logic [DCW-1:0]           deq_count,
  output logic [CW-1:0]            count,
  output logic                     empty,
  output logic                     full
);

  logic [DEPTH-1:0][ENTRY_W-1:0] mem_q, mem_d;
  logic [LOGDEPTH-1:0]           head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]                 count_q, count_d;
  logic [CW-1:0]                 n_in, n_out;
  logic [CW:0]                   free_slots;
  logic                          enq_fire;
  logic [LOGDEPTH-1:0]           wr_ptr, rd_ptr;

  // Space check uses current occupancy only; a same-cycle dequeue never
  // frees room for a same-cycle enqueue.
  assign free_slots = (CW+1)'(DEPTH) - {1'b0, count_q};
  assign enq_ready  = free_slots >= (CW+1)'(IN_W);
  assign enq_fire   = enq_valid & enq_ready & ~flush & reset;
  assign count      = count_q;
  assign empty      = (count_q == '0);
  assign full       = ~enq_ready;

  // Compact the masked lanes into consecutive slots starting at tail.
  always_comb begin
    mem_d  = mem_q;
    n_in   = '0;
    wr_ptr = tail_q;
    for (int i = 0; i < IN_W; i++) begin
      if (enq_fire && enq_mask[i]) begin
        mem_d[wr_ptr] = enq_data[i*ENTRY_W +: ENTRY_W];
        wr_ptr        = wr_ptr + 1'b1;
        n_in          = n_in + 1'b1;
      end
    end
  end

  // Clamp the retire count to what decode can see and what is present.
  always_comb begin
    n_out = CW'(deq_count);
    if (n_out > CW'(OUT_W)) n_out = CW'(OUT_W);
    if (n_out > count_q)    n_out = count_q;
  end

  // Pointer/occupancy update; flush discards both enqueue and dequeue.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + n_out[LOGDEPTH-1:0];
      tail_d  = tail_q + n_in[LOGDEPTH-1:0];
      count_d = count_q + n_in - n_out;
    end
  end

  // Control state with synchronous active-low reset (priority over flush).
  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is never cleared; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Present the oldest OUT_W entries in age order, zero beyond occupancy.
  always_comb begin
    deq_data  = '0;
    deq_valid = '0;
    rd_ptr    = head_q;
    for (int j = 0; j < OUT_W; j++) begin
      if (count_q > CW'(j)) begin
        deq_valid[j]                     = 1'b1;
        deq_data[j*ENTRY_W +: ENTRY_W]   = mem_q[rd_ptr];
      end
      rd_ptr = rd_ptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_queue_mw.sv
// Directed bench for fetch_queue_mw: vector table plus a wrap/steady-state
// sequence checked against a reference queue.
module tb_fetch_queue_mw;

  localparam int EW = 64;

  logic           clk = 1'b0;
  logic           reset, flush, enq_valid;
  logic [3:0]     enq_mask;
  logic [4*EW-1:0] enq_data;
  logic           enq_ready;
  logic [4*EW-1:0] deq_data;
  logic [3:0]     deq_valid;
  logic [2:0]     deq_count;
  logic [4:0]     count;
  logic           empty, full;

  int passed = 0;
  int total  = 0;

  fetch_queue_mw dut (
    .clk(clk), .reset(reset), .flush(flush),
    .enq_valid(enq_valid), .enq_mask(enq_mask), .enq_data(enq_data),
    .enq_ready(enq_ready), .deq_data(deq_data), .deq_valid(deq_valid),
    .deq_count(deq_count), .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       fl;
    logic       ev;
    logic [3:0] mask;
    int         g;
    logic [2:0] dc;
    int         cnt;
    logic       rdy;
    logic [3:0] vld;
    logic [63:0] s0;
    logic [63:0] s1;
  } vec_t;

  vec_t vt[$];

  // Lane i of group g carries g*16+i.
  function automatic logic [4*EW-1:0] grp(input int g);
    logic [4*EW-1:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i*EW +: EW] = 64'(g*16 + i);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add(input logic rst, input logic fl, input logic ev, input logic [3:0] mask,
                     input int g, input logic [2:0] dc, input int cnt, input logic rdy,
                     input logic [3:0] vld, input logic [63:0] s0, input logic [63:0] s1);
    vec_t v;
    v.rst = rst; v.fl = fl; v.ev = ev; v.mask = mask; v.g = g; v.dc = dc;
    v.cnt = cnt; v.rdy = rdy; v.vld = vld; v.s0 = s0; v.s1 = s1;
    vt.push_back(v);
  endtask

  task automatic check_outputs(input string tag, input int cnt, input logic rdy,
                               input logic [3:0] vld, input logic [63:0] s0, input logic [63:0] s1);
    chk({tag, " count"}, 64'(count), 64'(cnt));
    chk({tag, " enq_ready"}, 64'(enq_ready), 64'(rdy));
    chk({tag, " full"}, 64'(full), 64'(!rdy));
    chk({tag, " empty"}, 64'(empty), 64'(cnt == 0));
    chk({tag, " deq_valid"}, 64'(deq_valid), 64'(vld));
    if (vld[0]) chk({tag, " slot0"}, deq_data[0 +: EW], s0);
    if (vld[1]) chk({tag, " slot1"}, deq_data[EW +: EW], s1);
    for (int j = 0; j < 4; j++)
      if (!vld[j]) chk({tag, " slot_zero"}, deq_data[j*EW +: EW], 64'h0);
  endtask

  logic [63:0] mq[$];
  int          mcnt;
  logic        mrdy;
  int          nout;

  initial begin
    reset = 1'b0; flush = 1'b0; enq_valid = 1'b0; enq_mask = '0;
    enq_data = '0; deq_count = '0;

    //  rst fl ev mask  g  dc  cnt rdy vld    s0      s1
    add(0, 0, 1, 4'hF, 1, 0,  0, 1, 4'h0, 0,      0);      // reset held
    add(0, 0, 1, 4'hF, 1, 0,  0, 1, 4'h0, 0,      0);
    add(1, 0, 1, 4'hA, 1, 0,  2, 1, 4'h3, 64'h11, 64'h13); // sparse compaction
    add(1, 0, 0, 4'h0, 0, 2,  0, 1, 4'h0, 0,      0);
    add(1, 0, 1, 4'hF, 2, 0,  4, 1, 4'hF, 64'h20, 64'h21); // fill
    add(1, 0, 1, 4'hF, 3, 0,  8, 1, 4'hF, 64'h20, 64'h21);
    add(1, 0, 1, 4'hF, 4, 0, 12, 1, 4'hF, 64'h20, 64'h21);
    add(1, 0, 1, 4'hF, 5, 0, 16, 0, 4'hF, 64'h20, 64'h21);
    add(1, 0, 1, 4'hF, 6, 0, 16, 0, 4'hF, 64'h20, 64'h21); // dropped group
    add(1, 0, 0, 4'h0, 0, 4, 12, 1, 4'hF, 64'h30, 64'h31);
    add(1, 0, 0, 4'h0, 0, 4,  8, 1, 4'hF, 64'h40, 64'h41);
    add(1, 0, 0, 4'h0, 0, 4,  4, 1, 4'hF, 64'h50, 64'h51);
    add(1, 0, 0, 4'h0, 0, 2,  2, 1, 4'h3, 64'h52, 64'h53);
    add(1, 0, 0, 4'h0, 0, 4,  0, 1, 4'h0, 0,      0);      // over-request
    add(1, 0, 1, 4'h1, 7, 0,  1, 1, 4'h1, 64'h70, 0);
    add(1, 0, 1, 4'h0, 8, 0,  1, 1, 4'h1, 64'h70, 0);      // empty mask no-op
    add(1, 0, 0, 4'h0, 0, 7,  0, 1, 4'h0, 0,      0);      // request beyond OUT_W
    add(1, 0, 1, 4'hF, 8, 0,  4, 1, 4'hF, 64'h80, 64'h81);
    add(1, 0, 1, 4'hF, 9, 0,  8, 1, 4'hF, 64'h80, 64'h81);
    add(1, 0, 1, 4'h1,10, 0,  9, 1, 4'hF, 64'h80, 64'h81);
    add(1, 1, 1, 4'hF,11, 3,  0, 1, 4'h0, 0,      0);      // flush + enq
    add(1, 0, 1, 4'h3,12, 0,  2, 1, 4'h3, 64'hC0, 64'hC1);
    add(0, 0, 1, 4'hF,13, 0,  0, 1, 4'h0, 0,      0);      // reset mid-stream
    add(1, 0, 1, 4'h4,14, 0,  1, 1, 4'h1, 64'hE2, 0);

    foreach (vt[k]) begin
      @(negedge clk);
      reset = vt[k].rst; flush = vt[k].fl; enq_valid = vt[k].ev;
      enq_mask = vt[k].mask; enq_data = grp(vt[k].g); deq_count = vt[k].dc;
      @(posedge clk); #1;
      check_outputs($sformatf("vec%0d", k), vt[k].cnt, vt[k].rdy, vt[k].vld, vt[k].s0, vt[k].s1);
    end

    // Steady enqueue of 4 with retire of 3 per cycle across pointer wrap.
    mq.delete();
    mq.push_back(64'hE2);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      reset = 1'b1; flush = 1'b0; enq_valid = 1'b1; enq_mask = 4'hF;
      enq_data = grp(32 + c); deq_count = 3'd3;
      mcnt = mq.size();
      mrdy = (16 - mcnt) >= 4;
      nout = (mcnt < 3) ? mcnt : 3;
      for (int n = 0; n < nout; n++) void'(mq.pop_front());
      if (mrdy) for (int i = 0; i < 4; i++) mq.push_back(64'((32 + c)*16 + i));
      @(posedge clk); #1;
      mcnt = mq.size();
      chk($sformatf("wrap%0d count", c), 64'(count), 64'(mcnt));
      chk($sformatf("wrap%0d enq_ready", c), 64'(enq_ready), 64'((16 - mcnt) >= 4));
      for (int j = 0; j < 4; j++)
        if (j < mcnt) chk($sformatf("wrap%0d slot%0d", c, j), deq_data[j*EW +: EW], mq[j]);
    end

    @(negedge clk);
    enq_valid = 1'b0; deq_count = '0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
